regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 49 ++++
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 18 +
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared processor constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;
  localparam int unsigned DEF_SIZE = 32;
  localparam int unsigned DEF_NREG = 32;
  localparam int unsigned AW       = 5;

  typedef logic [AW-1:0] addr_t;

  // Identity of the most recently granted write-back requester.
  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } grant_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Decode-issue, write-back request, hazard lookup and register-file write-port bundle.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned SIZE = DEF_SIZE
);
  logic            issueValid;
  addr_t           issueAddr;
  logic            issueReady;

  logic            reqValid0;
  addr_t           reqAddr0;
  logic [SIZE-1:0] reqData0;
  logic            reqReady0;

  logic            reqValid1;
  addr_t           reqAddr1;
  logic [SIZE-1:0] reqData1;
  logic            reqReady1;

  addr_t           addrA;
  addr_t           addrB;
  logic            busyA;
  logic            busyB;

  logic            regWrite;
  addr_t           addrC;
  logic [SIZE-1:0] writeData;

  modport master (
    output issueValid, issueAddr,
    output reqValid0, reqAddr0, reqData0,
    output reqValid1, reqAddr1, reqData1,
    output addrA, addrB,
    input  issueReady, reqReady0, reqReady1,
    input  busyA, busyB,
    input  regWrite, addrC, writeData
  );

  modport slave (
    input  issueValid, issueAddr,
    input  reqValid0, reqAddr0, reqData0,
    input  reqValid1, reqAddr1, reqData1,
    input  addrA, addrB,
    output issueReady, reqReady0, reqReady1,
    output busyA, busyB,
    output regWrite, addrC, writeData
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  grant_e     lastGrant,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (lastGrant == G0) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Destination-register pending scoreboard plus arbitration of ALU/memory write-backs
// onto a single registered register-file write port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned SIZE = DEF_SIZE,
  parameter int unsigned NREG = DEF_NREG
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  logic [NREG-1:0] pending, pending_nxt;
  grant_e          last_grant, last_grant_nxt;
  logic [1:0]      grant;
  logic            accept;
  logic            issue_fire;
  addr_t           acc_addr;
  logic [SIZE-1:0] acc_data;

  logic            wr_q;
  addr_t           addr_q;
  logic [SIZE-1:0] data_q;

  rr_arbiter2 u_rr_arbiter2 (
    .valid    ({bus.reqValid1, bus.reqValid0}),
    .lastGrant(last_grant),
    .grant    (grant)
  );

  assign accept     = |grant;
  assign acc_addr   = grant[1] ? bus.reqAddr1 : bus.reqAddr0;
  assign acc_data   = grant[1] ? bus.reqData1 : bus.reqData0;
  assign issue_fire = bus.issueValid & bus.issueReady & (bus.issueAddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      last_grant <= G1;
    end else begin
      pending    <= pending_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Clear is applied after set so a same-register issue and write leave the bit at 0.
  always_comb begin
    pending_nxt = pending;
    if (issue_fire) pending_nxt[bus.issueAddr] = 1'b1;
    if (accept)     pending_nxt[acc_addr] = 1'b0;
    pending_nxt[0] = 1'b0;
    last_grant_nxt = last_grant;
    if (accept) last_grant_nxt = grant[1] ? G1 : G0;
  end

  always_comb begin
    bus.reqReady0  = grant[0];
    bus.reqReady1  = grant[1];
    bus.issueReady = !pending[bus.issueAddr] | (bus.issueAddr == '0);
    bus.busyA      = pending[bus.addrA] | (wr_q & (addr_q == bus.addrA) & (bus.addrA != '0));
    bus.busyB      = pending[bus.addrB] | (wr_q & (addr_q == bus.addrB) & (bus.addrB != '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= accept & (acc_addr != '0);
      if (accept) begin
        addr_q <= acc_addr;
        data_q <= acc_data;
      end
    end
  end

  assign bus.regWrite  = wr_q;
  assign bus.addrC     = addr_q;
  assign bus.writeData = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter with a queue-based write-port scoreboard.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wb_arbiter_if #(.SIZE(32)) bus ();

  regfile_wb_arbiter #(.SIZE(32), .NREG(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t  q[$];
  bit   pend[32];
  int   last;
  bit   fl_v;
  logic [4:0] fl_a;

  logic [1:0] obs_g;
  logic       obs_ir, obs_ba, obs_rw;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    last = 1;
    fl_v = 1'b0;
    fl_a = '0;
    q.delete();
  endtask

  // Drive one cycle of stimulus, check combinational responses against the model,
  // then advance the model over the coming clock edge.
  task automatic step(input bit iv, input logic [4:0] ia,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] aa, input logic [4:0] ab);
    int  g;
    bit  ir, acc;
    logic [4:0] wa;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    bus.issueValid = iv; bus.issueAddr = ia;
    bus.reqValid0 = v0; bus.reqAddr0 = a0; bus.reqData0 = d0;
    bus.reqValid1 = v1; bus.reqAddr1 = a1; bus.reqData1 = d1;
    bus.addrA = aa; bus.addrB = ab;
    #1;
    if (v0 && v1) g = (last == 0) ? 1 : 0;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    else          g = -1;
    ir = !pend[ia] || (ia == 0);
    chk("reqReady0", bus.reqReady0, g == 0);
    chk("reqReady1", bus.reqReady1, g == 1);
    chk("issueReady", bus.issueReady, ir);
    chk("busyA", bus.busyA, pend[aa] || (fl_v && fl_a == aa && aa != 0));
    chk("busyB", bus.busyB, pend[ab] || (fl_v && fl_a == ab && ab != 0));
    obs_g  = {bus.reqReady1, bus.reqReady0};
    obs_ir = bus.issueReady;
    obs_ba = bus.busyA;
    obs_rw = bus.regWrite;
    acc = (g >= 0);
    wa  = (g == 1) ? a1 : a0;
    wd  = (g == 1) ? d1 : d0;
    if (iv && ir && ia != 0) pend[ia] = 1'b1;
    if (acc) begin
      pend[wa] = 1'b0;
      last = g;
    end
    pend[0] = 1'b0;
    fl_v = acc && (wa != 0);
    fl_a = wa;
    if (fl_v) q.push_back('{a: wa, d: wd, c: cyc + 1});
  endtask

  task automatic idle(input logic [4:0] aa);
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.regWrite) begin
        if (q.size() == 0) chk("spurious_write", 1, 0);
        else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addrC", bus.addrC, e.a);
          chk("wr_data", bus.writeData, e.d);
          chk("wr_latency_cycle", cyc, e.c);
        end
      end else if (q.size() > 0 && q[0].c <= cyc) begin
        chk("missing_write", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int run;
    bus.issueValid = 0; bus.issueAddr = 0;
    bus.reqValid0 = 0; bus.reqAddr0 = 0; bus.reqData0 = 0;
    bus.reqValid1 = 0; bus.reqAddr1 = 0; bus.reqData1 = 0;
    bus.addrA = 0; bus.addrB = 0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_regWrite", bus.regWrite, 0);
    chk("rst_addrC", bus.addrC, 0);
    chk("rst_writeData", bus.writeData, 0);
    chk("rst_issueReady", bus.issueReady, 1);
    @(posedge clk); #2 rst = 1'b1;

    // Contention from reset: r1 on ALU, r2 on memory, alternating grants.
    run = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, 0, 0);
      chk("rr_grant_seq", obs_g, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0 && obs_rw) run++;
    end
    idle(0);
    if (obs_rw) run++;
    chk("rr_regWrite_run", run, 4);

    // Issue r5, then ALU writes r5=0xDEAD.
    step(1, 5'd5, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    idle(5'd5);
    chk("r5_pending_busyA", obs_ba, 1);
    step(0, 0, 1, 5'd5, 32'hDEAD, 0, 0, 0, 5'd5, 0);
    idle(5'd5);
    chk("r5_inflight_busyA", obs_ba, 1);
    chk("r5_inflight_regWrite", obs_rw, 1);
    idle(5'd5);
    chk("r5_after_busyA", obs_ba, 0);

    // Address 0 handling.
    step(0, 0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0);
    chk("r0_ready0", obs_g, 2'b01);
    idle(0);
    chk("r0_no_regWrite", obs_rw, 0);
    step(1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_issueReady", obs_ir, 1);
    idle(0);
    chk("r0_busy", obs_ba, 0);

    // Same-cycle issue and write to pending r7.
    step(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd7, 0, 0, 0, 1, 5'd7, 32'h77, 5'd7, 0);
    chk("r7_issue_refused", obs_ir, 0);
    step(1, 5'd7, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    chk("r7_issueReady_after", obs_ir, 1);
    step(0, 0, 1, 5'd7, 32'h777, 0, 0, 0, 0, 0);

    // Write-after-write attempt on r9.
    step(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r9_second_issue", obs_ir, 0);
    step(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r9_held", obs_ir, 0);
    step(1, 5'd9, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
    chk("r9_refused_at_write", obs_ir, 0);
    step(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r9_released", obs_ir, 1);

    // Randomized traffic with frequent address collisions.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 15)),
           $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));

    // Reset in the cycle after an acceptance.
    step(1, 5'd12, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 5'd3, 32'h3333, 1, 5'd3, 32'h3333, 5'd12, 0);
    @(posedge clk); #1;
    q.delete();
    chk("pre_reset_regWrite", bus.regWrite, 1);
    bus.reqValid1 = 0; bus.addrA = 5'd12;
    rst = 1'b0;
    #1;
    chk("async_rst_regWrite", bus.regWrite, 0);
    chk("async_rst_busyA", bus.busyA, 0);
    chk("async_rst_issueReady", bus.issueReady, 1);
    model_reset();
    @(posedge clk); #2 rst = 1'b1;
    step(0, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 0, 0);
    chk("post_reset_tie", obs_g, 2'b01);
    for (int i = 0; i < 4; i++) idle(0);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
